subtree_result_collector: RTL and testbench

- Fan-in counterpart to the generated fan-out parent modules: N child instances report results upward, and this block merges them onto one parent channel.
- Round-robin arbitration across children; each forwarded word is tagged with its source child index.
- Tracks which children have reported at least once since the last clear, and raises all_done when every child has reported.
- Sits inside each generated parent, between its child instances and the parent's upward port.

---
 rtl/subtree_pkg.sv | 48 ++++
 rtl/subtree_result_collector_rr_arbiter.sv | 51 +++++
 rtl/subtree_result_collector.sv | 100 ++++++++++
 tb/tb_subtree_result_collector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/subtree_pkg.sv
// Shared definitions for the subtree fan-in logic.
//   N_CHILD_DEF / DATA_W_DEF : default child count and result width
//   child_idx_t              : source tag type for the default child count
//   rr_pick                  : round-robin selection over up to 16 requesters
package subtree_pkg;

    localparam int unsigned N_CHILD_DEF = 5;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned IDX_W_DEF   = $clog2(N_CHILD_DEF);
    localparam int unsigned MAX_CHILD   = 16;

    typedef logic [IDX_W_DEF-1:0] child_idx_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Rotate req so that bit ptr lands at position 0, take the lowest set bit,
    // then map that position back to the original requester index.
    function automatic rr_pick_t rr_pick(input logic [MAX_CHILD-1:0] req,
                                         input logic [3:0]           ptr,
                                         input int unsigned          n);
        logic [MAX_CHILD-1:0] rot;
        rr_pick_t             res;
        int unsigned          j;
        rot = '0;
        res = '0;
        for (int unsigned k = 0; k < MAX_CHILD; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                rot[k] = req[j];
            end
        end
        // Descending scan so the lowest rotated position wins.
        for (int k = MAX_CHILD - 1; k >= 0; k--) begin
            if (rot[k]) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                res.found = 1'b1;
                res.idx   = 4'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/subtree_result_collector_rr_arbiter.sv
// N-way round-robin arbiter with an internal priority pointer.
//   clk, rst   : clock, async active-high reset
//   req        : per-requester request
//   advance    : a grant was consumed; move pointer past the winner
//   grant      : one-hot grant (all zeros when no request)
//   grant_idx  : binary index of the winner
//   any_req    : at least one request is present
//   ptr        : current priority pointer
module rr_arbiter
    import subtree_pkg::*;
#(
    parameter  int unsigned N  = N_CHILD_DEF,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req,
    output logic [IW-1:0] ptr
);

    rr_pick_t      pick;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        pick      = rr_pick(MAX_CHILD'(req), 4'(ptr_q), N);
        any_req   = pick.found;
        grant_idx = IW'(pick.idx);
        grant     = '0;
        if (pick.found) grant = N'(1) << grant_idx;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/subtree_result_collector.sv
// Merges N_CHILD child result channels onto one upward channel.
//   clk, rst      : clock, async active-high reset
//   child_valid   : per-child result valid
//   child_data    : packed child results, child i at [i*DATA_W +: DATA_W]
//   child_ready   : per-child accept, at most one bit high
//   up_valid/ready/data/src : registered upward channel, src tags the child
//   clear         : synchronous clear of done tracking
//   done_mask     : sticky per-child "has reported" flags
//   all_done      : every child has reported since the last clear
module subtree_result_collector
    import subtree_pkg::*;
#(
    parameter  int unsigned N_CHILD = N_CHILD_DEF,
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    localparam int unsigned IDX_W   = $clog2(N_CHILD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CHILD-1:0]    child_valid,
    input  logic [N_CHILD*DATA_W-1:0] child_data,
    output logic [N_CHILD-1:0]    child_ready,
    output logic                  up_valid,
    input  logic                  up_ready,
    output logic [DATA_W-1:0]     up_data,
    output logic [IDX_W-1:0]      up_src,
    input  logic                  clear,
    output logic [N_CHILD-1:0]    done_mask,
    output logic                  all_done
);

    logic               up_valid_q, up_valid_d;
    logic [DATA_W-1:0]  up_data_q, up_data_d;
    logic [IDX_W-1:0]   up_src_q, up_src_d;
    logic [N_CHILD-1:0] done_mask_q, done_mask_d;
    logic               all_done_q;

    logic               load;
    logic               hs;
    logic [N_CHILD-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_req;
    logic [IDX_W-1:0]   rr_ptr;

    // The output register frees up when empty or being drained this cycle.
    assign load = ~up_valid_q | up_ready;
    assign hs   = load & any_req;

    rr_arbiter #(
        .N (N_CHILD)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (child_valid),
        .advance   (hs),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req),
        .ptr       (rr_ptr)
    );

    always_comb begin
        child_ready = hs ? grant : '0;
        up_valid_d  = up_valid_q;
        up_data_d   = up_data_q;
        up_src_d    = up_src_q;
        if (load) begin
            up_valid_d = any_req;
            if (any_req) begin
                up_data_d = child_data[grant_idx*DATA_W +: DATA_W];
                up_src_d  = grant_idx;
            end
        end
        // Clear first, then record the winner of this cycle.
        done_mask_d = clear ? '0 : done_mask_q;
        if (hs) done_mask_d = done_mask_d | grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_valid_q  <= 1'b0;
            up_data_q   <= '0;
            up_src_q    <= '0;
            done_mask_q <= '0;
            all_done_q  <= 1'b0;
        end else begin
            up_valid_q  <= up_valid_d;
            up_data_q   <= up_data_d;
            up_src_q    <= up_src_d;
            done_mask_q <= done_mask_d;
            all_done_q  <= &done_mask_d;
        end
    end

    assign up_valid  = up_valid_q;
    assign up_data   = up_data_q;
    assign up_src    = up_src_q;
    assign done_mask = done_mask_q;
    assign all_done  = all_done_q;

endmodule

// File: tb/tb_subtree_result_collector.sv
module tb_subtree_result_collector;

    localparam int NC = 5;
    localparam int DW = 16;
    localparam int IW = 3;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     child_valid;
    logic [NC*DW-1:0]  child_data;
    logic [NC-1:0]     child_ready;
    logic              up_valid;
    logic              up_ready;
    logic [DW-1:0]     up_data;
    logic [IW-1:0]     up_src;
    logic              clear;
    logic [NC-1:0]     done_mask;
    logic              all_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-child pending words fed to the DUT.
    logic [DW-1:0] feed [NC][8];
    int            head [NC];
    int            cnt  [NC];

    // Expected upward words in order: {src, data}.
    logic [IW+DW-1:0] exp_q[$];

    subtree_result_collector #(
        .N_CHILD (NC),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .up_data     (up_data),
        .up_src      (up_src),
        .clear       (clear),
        .done_mask   (done_mask),
        .all_done    (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic apply_feeds();
        for (int i = 0; i < NC; i++) begin
            child_valid[i] = head[i] < cnt[i];
            child_data[i*DW +: DW] = (head[i] < cnt[i]) ? feed[i][head[i]] : '0;
        end
    endtask

    task automatic add_word(input int ch, input logic [DW-1:0] d);
        feed[ch][cnt[ch]] = d;
        cnt[ch]++;
    endtask

    task automatic expect_word(input int src, input logic [DW-1:0] d);
        exp_q.push_back({IW'(src), d});
    endtask

    // Called at a negedge; advances one clock and returns at the next negedge.
    task automatic step();
        logic [NC-1:0] hs;
        hs = child_valid & child_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) if (hs[i]) head[i]++;
        clear = 1'b0;
        apply_feeds();
        @(negedge clk);
    endtask

    // Scoreboard monitor: pops on every upward handshake.
    initial begin
        logic [IW+DW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && up_valid && up_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got src %0d data %0h, expected none",
                             up_src, up_data);
                end else begin
                    e = exp_q.pop_front();
                    check("up_src", 32'(up_src), 32'(e[IW+DW-1:DW]));
                    check("up_data", 32'(up_data), 32'(e[DW-1:0]));
                end
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1;
        child_valid = '0;
        child_data = '0;
        up_ready = 1'b1;
        clear = 1'b0;
        for (int i = 0; i < NC; i++) begin
            head[i] = 0;
            cnt[i] = 0;
        end

        // 1: reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_up_valid", 32'(up_valid), 0);
        check("rst_child_ready", 32'(child_ready), 0);
        check("rst_done_mask", 32'(done_mask), 0);
        check("rst_all_done", 32'(all_done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_up_valid", 32'(up_valid), 0);
        check("idle_child_ready", 32'(child_ready), 0);

        // 2: children 1,2,4 valid -> 1,2,4
        add_word(1, 16'h1111);
        add_word(2, 16'h2222);
        add_word(4, 16'h4444);
        expect_word(1, 16'h1111);
        expect_word(2, 16'h2222);
        expect_word(4, 16'h4444);
        apply_feeds();
        #1;
        check("t2_first_grant", 32'(child_ready), 32'b00010);
        check("t2_latency_valid0", 32'(up_valid), 0);
        step();
        check("t2_valid_after_1", 32'(up_valid), 1);
        check("t2_grant2", 32'(child_ready), 32'b00100);
        step();
        check("t2_grant4", 32'(child_ready), 32'b10000);
        step();
        check("t2_src4", 32'(up_src), 4);
        check("t2_no_grant", 32'(child_ready), 0);
        step();
        check("t2_drain", 32'(up_valid), 0);
        check("t2_mask", 32'(done_mask), 32'b10110);

        // 3: all valid, pointer back at 0 -> 0,1,2,3,4,0
        clear = 1'b1;
        step();
        check("t3_cleared", 32'(done_mask), 0);
        add_word(0, 16'hA000);
        add_word(0, 16'hA001);
        add_word(1, 16'hA100);
        add_word(2, 16'hA200);
        add_word(3, 16'hA300);
        add_word(4, 16'hA400);
        expect_word(0, 16'hA000);
        expect_word(1, 16'hA100);
        expect_word(2, 16'hA200);
        expect_word(3, 16'hA300);
        expect_word(4, 16'hA400);
        expect_word(0, 16'hA001);
        apply_feeds();
        #1;
        check("t3_grant0", 32'(child_ready), 32'b00001);
        repeat (4) step();
        check("t3_src3", 32'(up_src), 3);
        check("t3_not_done_yet", 32'(all_done), 0);
        step();
        check("t3_src4", 32'(up_src), 4);
        check("t3_all_done", 32'(all_done), 1);
        check("t3_mask_full", 32'(done_mask), 32'b11111);
        step();
        check("t3_wrap_src0", 32'(up_src), 0);
        step();
        check("t3_drain", 32'(up_valid), 0);

        // 4: stall with BEEF from child 3 held, then child 4 next
        up_ready = 1'b0;
        add_word(3, 16'hBEEF);
        add_word(4, 16'h4321);
        expect_word(3, 16'hBEEF);
        expect_word(4, 16'h4321);
        apply_feeds();
        #1;
        check("t4_grant3", 32'(child_ready), 32'b01000);
        step();
        for (int c = 0; c < 4; c++) begin
            check("t4_stall_valid", 32'(up_valid), 1);
            check("t4_stall_data", 32'(up_data), 32'hBEEF);
            check("t4_stall_src", 32'(up_src), 3);
            check("t4_stall_ready", 32'(child_ready), 0);
            step();
        end
        up_ready = 1'b1;
        #1;
        check("t4_grant4", 32'(child_ready), 32'b10000);
        step();
        check("t4_src4", 32'(up_src), 4);
        step();
        check("t4_drain", 32'(up_valid), 0);

        // 5: clear coincident with child-2 handshake, mask full
        check("t5_mask_before", 32'(done_mask), 32'b11111);
        add_word(2, 16'h2C2C);
        apply_feeds();
        clear = 1'b1;
        #1;
        check("t5_grant2", 32'(child_ready), 32'b00100);
        step();
        check("t5_mask", 32'(done_mask), 32'b00100);
        check("t5_all_done", 32'(all_done), 0);

        // 6: async reset with a word held and pointer at 3; this word is dropped
        up_ready = 1'b0;
        #1;
        check("t6_held", 32'(up_valid), 1);
        check("t6_ptr_before", 32'(dut.rr_ptr), 3);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(up_valid), 0);
        check("t6_rst_ptr", 32'(dut.rr_ptr), 0);
        check("t6_rst_mask", 32'(done_mask), 0);
        @(negedge clk);
        rst = 1'b0;
        up_ready = 1'b1;
        add_word(1, 16'h6101);
        add_word(3, 16'h6303);
        expect_word(1, 16'h6101);
        expect_word(3, 16'h6303);
        apply_feeds();
        #1;
        check("t6_grant1_first", 32'(child_ready), 32'b00010);
        step();
        check("t6_grant3", 32'(child_ready), 32'b01000);
        step();
        step();

        // Drain scoreboard with a bounded wait.
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
